// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter and write sequencer for one shared
// WIDTH-bit register. Each grant makes exactly one write into Q, or a locked
// burst of up to LOCK_MAX writes. Every output comes straight from a flop.
// Optional feature macro: REG_ARB_LOCK_EN adds the lock port and burst writes.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no owner; pick the next requester round-robin from ptr
// S_ARB   | owner granted; confirm its req is still up before writing
// S_WRITE | Q holds the owner's word, ack pulses; leave (or burst-stay)
module reg_share_arbiter #(
    parameter  int N_REQ    = 4,
    parameter  int WIDTH    = 8,
    parameter  int LOCK_MAX = 4,
    localparam int OW       = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] din,
`ifdef REG_ARB_LOCK_EN
    input  logic [N_REQ-1:0]       lock,
`endif
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic [OW-1:0]          owner,
    output logic                   busy,
    output logic [WIDTH-1:0]       Q
);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_WRITE} state_e;

    state_e              state_q, state_d;
    logic [OW-1:0]       ptr_q, ptr_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                busy_q, busy_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [OW-1:0]       pick;
    logic [OW-1:0]       ptr_next;
    logic [WIDTH-1:0]    din_arr [N_REQ];

`ifdef REG_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0]       burst_q, burst_d;
`endif

    if (N_REQ < 2 || N_REQ > 8 || LOCK_MAX < 1) begin : g_bad_param
        $error("reg_share_arbiter: N_REQ must be 2..8 and LOCK_MAX >= 1");
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_din
        assign din_arr[g] = din[g*WIDTH +: WIDTH];
    end

    // First requester at or after p, wrapping; returns 0 when none is set.
    function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [OW-1:0] p);
        logic found;
        int   idx;
        found   = 1'b0;
        rr_pick = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(p) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && r[idx[OW-1:0]]) begin
                found   = 1'b1;
                rr_pick = idx[OW-1:0];
            end
        end
    endfunction

    assign pick     = rr_pick(req, ptr_q);
    assign ptr_next = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Next-state and next-output decode; ack defaults low so it can only pulse.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        ack_d   = '0;
        busy_d  = busy_q;
        data_d  = data_q;
`ifdef REG_ARB_LOCK_EN
        burst_d = burst_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d       = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = S_ARB;
                end
            end
            S_ARB: begin
                if (req[owner_q]) begin
                    data_d         = din_arr[owner_q];
                    ack_d[owner_q] = 1'b1;
                    state_d        = S_WRITE;
`ifdef REG_ARB_LOCK_EN
                    burst_d        = CW'(1);
`endif
                end else begin
                    // Requester withdrew: abandon without touching ptr or Q.
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
`ifdef REG_ARB_LOCK_EN
                if (lock[owner_q] && req[owner_q] && burst_q < CW'(LOCK_MAX)) begin
                    data_d         = din_arr[owner_q];
                    ack_d[owner_q] = 1'b1;
                    burst_d        = burst_q + 1'b1;
                end else begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                    burst_d = '0;
                    state_d = S_IDLE;
                end
`else
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = ptr_next;
                state_d = S_IDLE;
`endif
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset aborts any pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            data_q  <= '0;
`ifdef REG_ARB_LOCK_EN
            burst_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
`ifdef REG_ARB_LOCK_EN
            burst_q <= burst_d;
`endif
        end
    end

    assign grant = grant_q;
    assign ack   = ack_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign Q     = data_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: directed scenarios plus randomized traffic
// predicted by a transaction-level round-robin model.
module tb_reg_share_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] din = '0;
`ifdef REG_ARB_LOCK_EN
    logic [N-1:0]   lock = '0;
`endif
    logic [N-1:0]   grant, ack;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   Q;

    int checks = 0;
    int failures = 0;

    int         mptr = 0;
    logic [7:0] mq = 8'h00;
    logic [7:0] dat [N];

    reg_share_arbiter #(.N_REQ(N), .WIDTH(W), .LOCK_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .din   (din),
`ifdef REG_ARB_LOCK_EN
        .lock  (lock),
`endif
        .grant (grant),
        .ack   (ack),
        .owner (owner),
        .busy  (busy),
        .Q     (Q)
    );

    always #50 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr(input logic [N-1:0] r, input int p);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (p + i) % N;
            if (r[k[1:0]]) return k;
        end
        return 0;
    endfunction

    task automatic drive_din();
        for (int i = 0; i < N; i++) din[i*W +: W] = dat[i];
    endtask

    task automatic check_idle(input string tag, input logic [7:0] q_exp);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_q"}, Q, q_exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mptr  = 0;
        mq    = 8'h00;
    endtask

    // Wait for the next ack and check it against the round-robin prediction.
    task automatic serve(input string tag, input bit gap_chk);
        int w;
        int cyc;
        w   = rr(req, mptr);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (ack == 0) chk({tag, "_qhold"}, Q, mq);
        end while (ack == 0 && cyc < 12);
        chk({tag, "_ack"}, ack, 32'(1) << w);
        chk({tag, "_q"}, Q, dat[w]);
        chk({tag, "_grant"}, grant, 32'(1) << w);
        chk({tag, "_owner"}, owner, w);
        chk({tag, "_busy"}, busy, 1);
        if (gap_chk) chk({tag, "_gap"}, cyc, 3);
        mq   = dat[w];
        mptr = (w + 1) % N;
    endtask

    initial begin
        int w;
        for (int i = 0; i < N; i++) dat[i] = 8'h00;

        // reset held with all requests up
        reset = 1'b0;
        req   = 4'b1111;
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
        drive_din();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("t1", 8'h00);
            chk("t1_owner", owner, 0);
        end

        // single request on requester 2
        reset  = 1'b1;
        req    = 4'b0100;
        dat[2] = 8'hA5;
        drive_din();
        @(negedge clk);
        chk("t2_grant", grant, 4'b0100);
        chk("t2_busy", busy, 1);
        chk("t2_ack0", ack, 0);
        chk("t2_owner", owner, 2);
        chk("t2_q0", Q, 8'h00);
        @(negedge clk);
        chk("t2_q", Q, 8'hA5);
        chk("t2_ack", ack, 4'b0100);
        req = 4'b0000;
        @(negedge clk);
        check_idle("t2_end", 8'hA5);

        // all requesters held: rotation 0,1,2,3,0 three cycles apart
        do_reset();
        req = 4'b1111;
        dat[0] = 8'h01; dat[1] = 8'h02; dat[2] = 8'h03; dat[3] = 8'h04;
        drive_din();
        for (int i = 0; i < 5; i++) begin
            w = rr(req, mptr);
            chk("t3_order", w, i % N);
            serve("t3", i != 0);
        end
        req = 4'b0000;
        @(negedge clk);

        // requester 1 withdraws during ARB: no write, ptr unchanged
        req    = 4'b0010;
        dat[1] = 8'h55;
        drive_din();
        @(negedge clk);
        chk("t4_grant", grant, 4'b0010);
        req = 4'b0000;
        @(negedge clk);
        check_idle("t4_drop", mq);
        req    = 4'b1010;
        dat[1] = 8'h66;
        dat[3] = 8'h77;
        drive_din();
        serve("t4_a", 1'b0);
        req[1] = 1'b0;
        serve("t4_b", 1'b1);
        req = 4'b0000;
        @(negedge clk);

        // reset arriving while a write is pending in ARB
        req    = 4'b0001;
        dat[0] = 8'h07;
        drive_din();
        @(negedge clk);
        chk("t5_grant", grant, 4'b0001);
        #10 reset = 1'b0;
        #1;
        check_idle("t5", 8'h00);
        chk("t5_owner", owner, 0);
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        mptr  = 0;
        mq    = 8'h00;
        @(negedge clk);
        check_idle("t5_after", 8'h00);

`ifdef REG_ARB_LOCK_EN
        // locked burst from requester 3, then grant moves to requester 0
        req    = 4'b1000;
        lock   = 4'b1000;
        dat[3] = 8'h3C;
        dat[0] = 8'h0C;
        drive_din();
        @(negedge clk);
        chk("t6_grant", grant, 4'b1000);
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_burst_ack", ack, 4'b1000);
            chk("t6_burst_q", Q, 8'h3C);
            chk("t6_burst_grant", grant, 4'b1000);
            chk("t6_burst_busy", busy, 1);
        end
        req  = 4'b0001;
        lock = 4'b0000;
        mptr = 0;
        mq   = 8'h3C;
        @(negedge clk);
        check_idle("t6_exit", 8'h3C);
        serve("t6_next", 1'b0);
        req = 4'b0000;
        @(negedge clk);
`endif

        // randomized traffic against the round-robin model
        req = 4'($urandom_range(1, 15));
        for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
        drive_din();
        for (int n = 0; n < 150; n++) begin
            w = rr(req, mptr);
            serve("rnd", n != 0);
            if ($urandom_range(0, 1) == 0) req[w] = 1'b0;
            else dat[w] = 8'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    dat[i] = 8'($urandom);
                end
            end
            if (req == 0) begin
                w      = int'($urandom_range(0, N - 1));
                req[w] = 1'b1;
                dat[w] = 8'($urandom);
            end
            drive_din();
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
        check_idle("rnd_end", mq);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
